// File: rtl/key_seq_pkg.sv
// Constants shared by the key transmitter and any detector that listens on the same byte bus.
package key_seq_pkg;

    localparam int BYTE_W          = 8;
    localparam int KEY_LEN_DEFAULT = 8;
    // Spells "n0_sP1c3" when read from byte 0 upward.
    localparam logic [63:0] KEY_DEFAULT = 64'h33_63_31_50_73_5F_30_6E;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/key_seq_rom.sv
// Combinational byte selector: maps a key index to its 8-bit slice of the packed key.
module key_seq_rom
    import key_seq_pkg::*;
#(
    parameter int                        LEN = KEY_LEN_DEFAULT,
    parameter logic [BYTE_W*LEN-1:0]     KEY = KEY_DEFAULT
) (
    input  logic [3:0]        idx,
    output logic [BYTE_W-1:0] q
);

    always_comb begin
        q = '0;
        for (int i = 0; i < LEN; i++) begin
            if (idx == 4'(i)) begin
                q = KEY[BYTE_W*i +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/key_seq_tx.sv
// Sends a fixed key one byte per valid/ready transfer after a start pulse, then pulses done.
module key_seq_tx
    import key_seq_pkg::*;
#(
    parameter int                        LEN = KEY_LEN_DEFAULT,
    parameter logic [BYTE_W*LEN-1:0]     KEY = KEY_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    output logic [BYTE_W-1:0] d,
    output logic              d_valid,
    output logic              busy,
    output logic              done
);

    if (LEN < 1 || LEN > 16) begin : g_len_chk
        $error("key_seq_tx: LEN must be in 1..16");
    end

    localparam logic [3:0] LAST = 4'(LEN - 1);

    state_t            state, state_nx;
    logic [3:0]        idx, idx_nx;
    logic              vld_nx;
    logic [BYTE_W-1:0] rom_q;
    logic [BYTE_W-1:0] d_nx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        vld_nx   = d_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                    vld_nx   = 1'b1;
                end
            end
            SEND: begin
                // Abort beats a coincident final transfer, so no done pulse follows.
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    vld_nx   = 1'b0;
                end else if (ready) begin
                    if (idx == LAST) begin
                        state_nx = DONE;
                        idx_nx   = '0;
                        vld_nx   = 1'b0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = '0;
                vld_nx   = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
                vld_nx   = 1'b0;
            end
        endcase
    end

    // Looking up the next index lets d be registered without an extra cycle of latency.
    key_seq_rom #(
        .LEN (LEN),
        .KEY (KEY)
    ) u_rom (
        .idx (idx_nx),
        .q   (rom_q)
    );

    assign d_nx = vld_nx ? rom_q : '0;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state   <= IDLE;
            idx     <= '0;
            d       <= '0;
            d_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            d       <= d_nx;
            d_valid <= vld_nx;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_key_seq_tx.sv
// Scoreboard bench for key_seq_tx: directed sends, backpressure, abort, reset and a model detector.
module tb_key_seq_tx;

    logic       clk = 1'b0;
    logic       clr_n, start, abort, ready;
    logic [7:0] d;
    logic       d_valid, busy, done;

    typedef struct packed {
        logic       is_done;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] kb [8] = '{8'h6E, 8'h30, 8'h5F, 8'h73, 8'h50, 8'h31, 8'h63, 8'h33};
    localparam logic [63:0] KEY_REF = 64'h3363_3150_735F_306E;

    int n_chk  = 0;
    int n_pass = 0;
    int done_seen = 0;
    int det_hits  = 0;

    logic [63:0] win;
    logic        det;

    key_seq_tx dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .abort   (abort),
        .ready   (ready),
        .d       (d),
        .d_valid (d_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Downstream detector model: matches when the last 8 transferred bytes form the key.
    always @(posedge clk) begin
        if (!clr_n) begin
            win <= '0;
            det <= 1'b0;
        end else if (d_valid && ready) begin
            win <= {d, win[63:8]};
            det <= ({d, win[63:8]} == KEY_REF);
        end else begin
            det <= 1'b0;
        end
    end

    // Monitor: every transfer and every done cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        ev_t e;
        if (clr_n === 1'b1) begin
            if (det) det_hits++;
            if (d_valid && ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra_byte: got %02h, required no transfer", d);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done || e.b !== d)
                        $display("FAIL sb_byte: got byte %02h, required %s %02h", d,
                                 e.is_done ? "done" : "byte", e.b);
                    else
                        n_pass++;
                end
            end
            if (done) begin
                n_chk++;
                done_seen++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra_done: got done, required nothing");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done)
                        $display("FAIL sb_done: got done, required byte %02h", e.b);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int nb, input bit with_done);
        for (int i = 0; i < nb; i++) exp_q.push_back('{is_done: 1'b0, b: kb[i]});
        if (with_done) exp_q.push_back('{is_done: 1'b1, b: 8'h00});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1);
    end

    initial begin
        int n, base_done, base_det;
        clr_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
        tick(); tick();
        chk("rst_d", d, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        clr_n = 1'b1;
        tick();

        // Plain send with ready tied high.
        push_seq(8, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_first_byte", d, 8'h6E);
        chk("t1_first_valid", d_valid, 1);
        chk("t1_busy", busy, 1);
        wait_done(n);
        chk("t1_done_latency", n, 8);
        chk("t1_detect", det, 1);
        tick();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_idle", busy, 0);

        // Three stalled cycles while 5F is presented.
        push_seq(8, 1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("t2_at_5f", d, 8'h5F);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_d", d, 8'h5F);
            chk("t2_hold_valid", d_valid, 1);
        end
        ready = 1'b1;
        tick();
        chk("t2_after_stall", d, 8'h73);
        wait_done(n);
        chk("t2_done_delay", n, 5);
        tick();
        chk("t2_idle", busy, 0);

        // Abort while 50 is presented; 50 still transfers on that edge.
        base_done = done_seen;
        base_det  = det_hits;
        push_seq(5, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("t3_at_50", d, 8'h50);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3_abort_valid", d_valid, 0);
        chk("t3_abort_d", d, 0);
        chk("t3_abort_busy", busy, 0);
        repeat (10) tick();
        chk("t3_no_done", done_seen - base_done, 0);
        chk("t3_no_match", det_hits - base_det, 0);
        push_seq(8, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_replay_first", d, 8'h6E);
        wait_done(n);
        chk("t3_replay_latency", n, 8);
        chk("t3_replay_detect", det, 1);
        tick();

        // start re-pulsed during SEND and during DONE is ignored.
        base_done = done_seen;
        push_seq(8, 1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(n);
        chk("t4_no_restart", n, 5);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_start_in_done_busy", busy, 0);
        chk("t4_start_in_done_valid", d_valid, 0);
        repeat (12) tick();
        chk("t4_one_done", done_seen - base_done, 1);
        chk("t4_stays_idle", busy, 0);

        // Reset for one cycle while 31 is presented.
        push_seq(5, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("t5_at_31", d, 8'h31);
        clr_n = 1'b0; tick(); clr_n = 1'b1;
        chk("t5_rst_d", d, 0);
        chk("t5_rst_valid", d_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        push_seq(8, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_restart_first", d, 8'h6E);
        wait_done(n);
        chk("t5_restart_latency", n, 8);
        chk("t5_restart_detect", det, 1);
        tick();

        // start and abort together in IDLE: start wins; abort then ends the send.
        push_seq(1, 0);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0;
        chk("t6_start_wins_valid", d_valid, 1);
        chk("t6_start_wins_d", d, 8'h6E);
        tick(); abort = 1'b0;
        chk("t6_abort_idle", busy, 0);

        // Abort coinciding with the final transfer suppresses done.
        base_done = done_seen;
        push_seq(8, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        chk("t6_at_33", d, 8'h33);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t6_last_abort_busy", busy, 0);
        chk("t6_last_abort_done", done, 0);
        repeat (5) tick();
        chk("t6_last_abort_no_done", done_seen - base_done, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
